// File: rtl/alu_exec_responder.sv
// Execute-stage ALU responder: one registered result per accepted request,
// plus the Y86-style ZF/SF/OF condition-code register and an accept counter.
//
// state | meaning
// EMPTY | no result held; in_ready=1
// FULL  | result held in out/OF_FLAG until out_ready; refills on the drain edge
module alu_exec_responder #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       alu_fun,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             OF_FLAG,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic [CNT_W-1:0] txn_count
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               of_q, of_d;
    logic               zf_q, zf_d;
    logic               sf_q, sf_d;
    logic               ccof_q, ccof_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res;
    logic               ovf;
    logic               accept;

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (alu_fun)
            2'b00: begin
                res = in1 + in2;
                ovf = (in1[MSB] == in2[MSB]) && (res[MSB] != in1[MSB]);
            end
            2'b01: begin
                res = in1 - in2;
                ovf = (in1[MSB] != in2[MSB]) && (res[MSB] != in1[MSB]);
            end
            2'b10:   res = in1 & in2;
            default: res = in1 ^ in2;
        endcase
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        of_d    = of_q;
        zf_d    = zf_q;
        sf_d    = sf_q;
        ccof_d  = ccof_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY:   if (in_valid) state_d = FULL;
            FULL:    if (out_ready && !in_valid) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        // All datapath loads are gated by accept so idle-bus X never reaches state.
        if (accept) begin
            out_d = res;
            of_d  = ovf;
            cnt_d = cnt_q + CNT_W'(1);
            if (set_cc) begin
                zf_d   = (res == '0);
                sf_d   = res[MSB];
                ccof_d = ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            of_q    <= 1'b0;
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            ccof_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            of_q    <= of_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            ccof_q  <= ccof_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out       = out_q;
    assign OF_FLAG   = of_q;
    assign cc_zf     = zf_q;
    assign cc_sf     = sf_q;
    assign cc_of     = ccof_q;
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_alu_exec_responder.sv
// Scoreboard bench for alu_exec_responder: directed requests push hand-computed
// results; a negedge monitor pops and compares on every output handshake.
module tb_alu_exec_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in1, in2;
    logic [1:0]  alu_fun;
    logic        set_cc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;
    logic        OF_FLAG;
    logic        cc_zf, cc_sf, cc_of;
    logic [15:0] txn_count;

    alu_exec_responder #(.WIDTH(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .alu_fun(alu_fun), .set_cc(set_cc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .OF_FLAG(OF_FLAG),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        of;
        logic        zf, sf, ccof;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          cyc    = 0;
    logic        m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
    logic [15:0] m_cnt = '0;

    localparam logic [1:0] F_ADD = 2'b00, F_SUB = 2'b01, F_AND = 2'b10, F_XOR = 2'b11;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL mon_unexpected: got result 0x%0h, expected none", out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_out", out, e.res);
                chk("mon_of", {63'd0, OF_FLAG}, {63'd0, e.of});
                chk("mon_cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, e.zf, e.sf, e.ccof});
                chk("mon_txn", {48'd0, txn_count}, {48'd0, e.cnt});
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        in1      = 'x;
        in2      = 'x;
        alu_fun  = 'x;
        set_cc   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted; the hand-computed expectation is pushed on accept.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                         input logic sc, input logic [63:0] eo, input logic eof);
        int   waited;
        bit   ok;
        exp_t e;
        waited   = 0;
        ok       = 1'b0;
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        alu_fun  = f;
        set_cc   = sc;
        while (!ok && waited < 20) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            waited++;
        end
        if (ok) begin
            m_cnt = m_cnt + 16'd1;
            if (sc) begin
                m_zf = (eo == 64'd0);
                m_sf = eo[63];
                m_of = eof;
            end
            e.res = eo; e.of = eof; e.zf = m_zf; e.sf = m_sf; e.ccof = m_of; e.cnt = m_cnt;
            sb.push_back(e);
        end else begin
            n_tot++;
            $display("FAIL issue_timeout: got no accept in %0d cycles, expected accept", waited);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int c0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in1 = '0; in2 = '0; alu_fun = '0; set_cc = 1'b0;
        #22;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out", out, 64'd0);
        chk("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        chk("rst_txn", {48'd0, txn_count}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(64'b100110, 64'b110001, F_AND, 1'b1, 64'b100000, 1'b0);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, F_ADD, 1'b1, 64'h8000_0000_0000_0000, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'd1, F_SUB, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        issue(64'hFFFF_FFFF_FFFF_FFD3, 64'hFFFF_FFFF_FFFF_FFD3, F_SUB, 1'b1, 64'd0, 1'b0);
        issue(64'h3C, 64'h0F, F_XOR, 1'b0, 64'h33, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, F_ADD, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        idle();
        idle();

        // Backpressure: held result must freeze while new operands wave at the input.
        out_ready = 1'b0;
        issue(64'd5, 64'd7, F_ADD, 1'b0, 64'd12, 1'b0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in1      = 64'd100 + 64'(k);
            in2      = 64'(k);
            alu_fun  = F_SUB;
            set_cc   = 1'b1;
            @(negedge clk);
            chk("stall_out", out, 64'd12);
            chk("stall_of", {63'd0, OF_FLAG}, 64'd0);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_txn", {48'd0, txn_count}, {48'd0, m_cnt});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue(64'h30, 64'h3, F_SUB, 1'b0, 64'h2D, 1'b0);
        idle();
        idle();

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, F_ADD, 1'b1, 64'h8000_0000_0000_0000, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out", out, 64'd0);
        chk("arst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        chk("arst_txn", {48'd0, txn_count}, 64'd0);
        sb.delete();
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_cnt = '0;
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_valid2", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;

        // Back-to-back stream: one accept per cycle.
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            issue(64'(i), 64'(2 * i), F_ADD, 1'b0, 64'(3 * i), 1'b0);
        chk("stream_cycles", 64'(cyc - c0), 64'd8);
        chk("stream_txn", {48'd0, txn_count}, 64'd8);

        // Walk the counter to its terminal value, then wrap.
        for (int k = 8; k < 65535; k++)
            issue(64'(k), 64'd0, F_ADD, 1'b0, 64'(k), 1'b0);
        chk("cnt_max", {48'd0, txn_count}, 64'hFFFF);
        issue(64'h1, 64'h1, F_AND, 1'b0, 64'h1, 1'b0);
        chk("cnt_wrap", {48'd0, txn_count}, 64'd0);
        idle();
        idle();
        chk("drained_valid", {63'd0, out_valid}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
